// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared constants, FSM encoding, port ids and boot table for the data-memory arbiter.
package pacote_memoria;

  localparam int unsigned LARG_DADOS = 32;
  localparam int unsigned LARG_END   = 7;
  localparam int unsigned N_BOOT     = 4;
  localparam int unsigned LARG_BOOT  = 2;

  typedef enum logic {
    INICIALIZA = 1'b0,
    OPERA      = 1'b1
  } estado_t;

  localparam logic PORTA_CPU = 1'b0;
  localparam logic PORTA_ES  = 1'b1;

  localparam logic [LARG_DADOS-1:0] VALOR_INIT [N_BOOT] = '{
    32'h0000_0007, 32'h0000_0041, 32'h0000_0051, 32'h0000_0049
  };

  // Boot words beyond the table are written as zero.
  function automatic logic [LARG_DADOS-1:0] valor_init(input int unsigned idx);
    logic [LARG_DADOS-1:0] valor;
    valor = '0;
    if (idx < N_BOOT) valor = VALOR_INIT[idx[LARG_BOOT-1:0]];
    return valor;
  endfunction

endpackage

// File: rtl/arbitro_memoria_dados_rr2.sv
// Two-way round-robin arbiter; one-hot combinational grant, last winner held in ultimo_q.
module arbitro_rr2 (
  input  logic clock_i,
  input  logic reset_i,
  input  logic habilita_i,
  input  logic req_cpu_i,
  input  logic req_es_i,
  output logic gnt_cpu_o,
  output logic gnt_es_o
);
  import pacote_memoria::*;

  logic ultimo_q;
  logic ultimo_d;

  // On a tie the port that did not win last time is served.
  always_comb begin
    gnt_cpu_o = 1'b0;
    gnt_es_o  = 1'b0;
    ultimo_d  = ultimo_q;
    if (habilita_i) begin
      if (req_cpu_i && req_es_i) begin
        gnt_cpu_o = (ultimo_q == PORTA_ES);
        gnt_es_o  = (ultimo_q == PORTA_CPU);
      end else begin
        gnt_cpu_o = req_cpu_i;
        gnt_es_o  = req_es_i;
      end
    end
    if (gnt_cpu_o)     ultimo_d = PORTA_CPU;
    else if (gnt_es_o) ultimo_d = PORTA_ES;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) ultimo_q <= PORTA_ES;
    else         ultimo_q <= ultimo_d;
  end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Data-memory front end: boot-word preload after reset, then round-robin Cpu/Es access with read-return tagging.
module arbitro_memoria_dados #(
  parameter int unsigned LARG_DADOS = 32,
  parameter int unsigned LARG_END   = 7,
  parameter int unsigned N_INIT     = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CpuReq,
  input  logic                  CpuWe,
  input  logic [LARG_END-1:0]   CpuEnd,
  input  logic [LARG_DADOS-1:0] CpuDadoEsc,
  output logic                  CpuGnt,
  output logic                  CpuValido,
  output logic [LARG_DADOS-1:0] CpuDadoLido,
  input  logic                  EsReq,
  input  logic                  EsWe,
  input  logic [LARG_END-1:0]   EsEnd,
  input  logic [LARG_DADOS-1:0] EsDadoEsc,
  output logic                  EsGnt,
  output logic                  EsValido,
  output logic [LARG_DADOS-1:0] EsDadoLido,
  output logic [LARG_END-1:0]   MemEnd,
  output logic [LARG_DADOS-1:0] MemDadoEsc,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [LARG_DADOS-1:0] MemDadoLido,
  output logic                  Pronto
);
  import pacote_memoria::*;

  localparam logic [LARG_END-1:0] CONT_ULTIMO = LARG_END'(N_INIT - 1);

  estado_t               estado_q, estado_d;
  logic [LARG_END-1:0]   cont_q, cont_d;
  logic [LARG_END-1:0]   end_q, end_d;
  logic [LARG_DADOS-1:0] dado_q, dado_d;
  logic                  tag_val_q, tag_val_d;
  logic                  tag_porta_q, tag_porta_d;
  logic                  gnt_cpu, gnt_es, habilita;

  assign habilita = (estado_q == OPERA) && !Reset;

  arbitro_rr2 u_rr2 (
    .clock_i    (Clock),
    .reset_i    (Reset),
    .habilita_i (habilita),
    .req_cpu_i  (CpuReq),
    .req_es_i   (EsReq),
    .gnt_cpu_o  (gnt_cpu),
    .gnt_es_o   (gnt_es)
  );

  // Reset gates every command and handshake so nothing leaks out while it is held.
  always_comb begin
    estado_d    = estado_q;
    cont_d      = cont_q;
    tag_val_d   = 1'b0;
    tag_porta_d = tag_porta_q;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemEnd      = end_q;
    MemDadoEsc  = dado_q;
    CpuGnt      = gnt_cpu;
    EsGnt       = gnt_es;
    Pronto      = habilita;
    CpuValido   = tag_val_q && (tag_porta_q == PORTA_CPU) && !Reset;
    EsValido    = tag_val_q && (tag_porta_q == PORTA_ES) && !Reset;
    CpuDadoLido = MemDadoLido;
    EsDadoLido  = MemDadoLido;
    if (!Reset) begin
      unique case (estado_q)
        INICIALIZA: begin
          MemWrite   = 1'b1;
          MemEnd     = cont_q;
          MemDadoEsc = LARG_DADOS'(valor_init(32'(cont_q)));
          cont_d     = cont_q + LARG_END'(1);
          if (cont_q == CONT_ULTIMO) estado_d = OPERA;
        end
        OPERA: begin
          if (gnt_cpu) begin
            MemEnd      = CpuEnd;
            MemDadoEsc  = CpuDadoEsc;
            MemWrite    = CpuWe;
            MemRead     = !CpuWe;
            tag_val_d   = !CpuWe;
            tag_porta_d = PORTA_CPU;
          end else if (gnt_es) begin
            MemEnd      = EsEnd;
            MemDadoEsc  = EsDadoEsc;
            MemWrite    = EsWe;
            MemRead     = !EsWe;
            tag_val_d   = !EsWe;
            tag_porta_d = PORTA_ES;
          end
        end
      endcase
    end
    end_d  = MemEnd;
    dado_d = MemDadoEsc;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q    <= INICIALIZA;
      cont_q      <= '0;
      end_q       <= '0;
      dado_q      <= '0;
      tag_val_q   <= 1'b0;
      tag_porta_q <= PORTA_CPU;
    end else begin
      estado_q    <= estado_d;
      cont_q      <= cont_d;
      end_q       <= end_d;
      dado_q      <= dado_d;
      tag_val_q   <= tag_val_d;
      tag_porta_q <= tag_porta_d;
    end
  end

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

- Shares the single-port data memory (128 × 32) between two requesters: the processor datapath port (Cpu) and an I/O / loader port (Es).
- Owns the memory command bus, including MemRead, MemWrite, address and write data.
- After reset it runs an initialization sequence that preloads fixed boot words into the memory. It then arbitrates round-robin, issuing at most one access per cycle.
- Sits between the datapath and the data memory, replacing direct datapath drive of the memory control lines.

## Interface

Parameters:
- LARG_DADOS, 32, data width
- LARG_END, 7, word address width (128 words)
- N_INIT, 4, number of boot words written after reset (≤ 2^LARG_END)

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- CpuReq  in  1  Cpu requests an access; held with fields stable until CpuGnt
- CpuWe  in  1  1 = write, 0 = read
- CpuEnd  in  LARG_END  word address
- CpuDadoEsc  in  LARG_DADOS  write data
- CpuGnt  out  1  access issued this cycle
- CpuValido  out  1  CpuDadoLido valid (read return)
- CpuDadoLido  out  LARG_DADOS  read data
- EsReq, EsWe, EsEnd, EsDadoEsc, EsGnt, EsValido, EsDadoLido: identical set for the Es port
- MemEnd  out  LARG_END  memory address
- MemDadoEsc  out  LARG_DADOS  memory write data
- MemRead  out  1  memory read command
- MemWrite  out  1  memory write command
- MemDadoLido  in  LARG_DADOS  memory read data, valid the cycle after MemRead
- Pronto  out  1  initialization complete, grants enabled

## Operation

FSM states:
- INICIALIZA, entered on reset:
  - Counter cont starts at 0.
  - Each cycle the block drives MemWrite=1, MemEnd=cont and MemDadoEsc=VALOR_INIT[cont], then increments cont.
  - After the write at cont = N_INIT−1, the FSM goes to OPERA.
  - No grants are issued; Req inputs are ignored (requesters keep waiting).
  - Pronto=0.
- OPERA:
  - Pronto=1.
  - Each cycle selects at most one requester:
    - only one Req high → that requester wins;
    - both high → the requester that did not win the most recent grant wins (pointer ultimo, reset value = Es, so Cpu wins the first tie).
  - Winner's fields drive MemEnd and MemDadoEsc. MemWrite=We and MemRead=!We; the winner's Gnt=1.
  - ultimo updates to the winner on every grant.
  - No Req → MemRead=MemWrite=0, MemEnd and MemDadoEsc hold their last values.
- Read returns:
  - A registered tag remembers which port issued a read in the previous cycle.
  - In the next cycle that port's Valido=1, and its DadoLido=MemDadoLido.
  - DadoLido is don't-care while Valido=0; the bench must only check it when Valido=1.
- Writes produce no Valido.
- Read-after-write to the same address in consecutive cycles must return the new data (memory ordering; no forwarding in this block).

## Timing

- Reset values:
  - FSM=INICIALIZA, cont=0, ultimo=Es, read tag cleared.
  - Pronto=0, all Gnt=0, all Valido=0, MemRead=0.
  - MemWrite becomes 1 in the first cycle after Reset deasserts (init write of address 0).
- Gnt, MemRead, MemWrite, MemEnd, MemDadoEsc: combinational from Req/We/fields and registered state. Gnt is asserted in the same cycle the memory command is issued.
- Read latency: grant in cycle T → Valido in T+1. Throughput is one access per cycle, so back-to-back reads from both ports pipeline.
- Init:
  - Occupies exactly N_INIT cycles after Reset deasserts.
  - Pronto rises in cycle N_INIT (counting the first post-reset cycle as 0).
  - First grant possible in that same cycle.
- Requester rule: Req held until Gnt. Req may be deasserted in the cycle after Gnt, or held to request again.
- Continuous dual requests alternate Cpu, Es, Cpu, … with no starvation.
- Reset mid-operation:
  - Aborts everything; a pending read return is suppressed (no Valido in the next cycle).
  - Init reruns and rewrites the boot words.
- Reset asserted while both ports request: no Gnt during Reset or INICIALIZA.

## Structure

- Package pacote_memoria holds:
  - LARG_DADOS, LARG_END;
  - the FSM state enum (INICIALIZA, OPERA);
  - port id constants (PORTA_CPU, PORTA_ES);
  - the boot table VALOR_INIT = {32'h7, 32'h41, 32'h51, 32'h49}.
- The arbiter core is one sub-module, arbitro_rr2: two requests plus the pointer in, one-hot grant out, ultimo register inside.
- The top level holds the FSM, the init counter, the command mux and the read tag.

## Test plan

1. Reset, then idle:
   - MemWrite is 1 for 4 cycles at addresses 0–3 with data 7, 0x41, 0x51, 0x49.
   - Pronto rises in cycle 4.
   - Cpu read of address 2 in cycle 4 → CpuGnt in cycle 4; CpuValido and CpuDadoLido=0x51 in cycle 5.
2. Requests held during init → no Gnt before Pronto. In cycle 4 both requests are present: Cpu is granted first, Es in cycle 5.
3. Both ports hold Req for 6 cycles → grants alternate Cpu, Es, Cpu, Es, Cpu, Es. Each read's Valido lands on the correct port one cycle after its Gnt.
4. Cpu writes 0xDEADBEEF to address 10 in cycle T; Es reads address 10 in cycle T+1 → EsDadoLido=0xDEADBEEF in T+2, and there is no CpuValido.
5. Cpu read granted in cycle T, Reset asserted in cycle T+1 → no CpuValido in T+1 or later. Pronto=0, and the init writes of addresses 0–3 repeat after Reset deasserts.
6. Only Es requests for 3 consecutive cycles (reads of addresses 0, 1, 3) → EsGnt in each cycle, EsDadoLido = 7, 0x41, 0x49 in the following cycles. The first tie after that grants Cpu.
